// File: rtl/osd_cdm_du_responder.sv
// ============================================================================
// osd_cdm_du_responder
// ----------------------------------------------------------------------------
// Core-side responder for the CDM debug-unit (du_*) interface, one per core.
// Local debug-group registers (du_adr_i[15:11] == DBG_GROUP) are served
// here; every other address is forwarded to the CPU SPR port. The block also
// tracks breakpoint halts and drives the pipeline stall.
//
// Local register map (offset = du_adr_i[10:0] inside the debug group):
//   0x000 DCTRL   bit0 BP_EN, other bits RAZ/WI
//   0x001 DSTAT   bit0 BP_STOP, bit1 TIMEOUT_ERR, write-1-to-clear
//   0x002 DHITCNT saturating count of qualified bp_hit pulses, any write
//                 clears (only with OSD_CDM_DU_HITCNT_EN, else RAZ/WI)
//   others        RAZ/WI, still acknowledged
//
// Optional feature macro: OSD_CDM_DU_HITCNT_EN (adds DHITCNT).
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   du_stall_i   CDM stall request (level)
//   du_stall_o   core halted by breakpoint
//   du_stb_i     access strobe, held by the CDM until du_ack_o
//   du_ack_o     one-cycle completion pulse
//   du_adr_i     register address
//   du_we_i      1 = write, 0 = read
//   du_dat_i     write data
//   du_dat_o     read data, held until the next read completes
//   cpu_stall    stall to pipeline (du_stall_i | bp_stall, registered)
//   bp_hit       one-cycle breakpoint/trap pulse from the core
//   spr_req      SPR request, held until spr_ack or timeout
//   spr_we       SPR write enable
//   spr_addr     SPR address
//   spr_wdata    SPR write data
//   spr_rdata    SPR read data, valid with spr_ack
//   spr_ack      SPR completion pulse
// ============================================================================
module osd_cdm_du_responder #(
    parameter logic [4:0]  DBG_GROUP = 5'd6,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        du_stall_i,
    output logic        du_stall_o,
    input  logic        du_stb_i,
    output logic        du_ack_o,
    input  logic [15:0] du_adr_i,
    input  logic        du_we_i,
    input  logic [31:0] du_dat_i,
    output logic [31:0] du_dat_o,
    output logic        cpu_stall,
    input  logic        bp_hit,
    output logic        spr_req,
    output logic        spr_we,
    output logic [15:0] spr_addr,
    output logic [31:0] spr_wdata,
    input  logic [31:0] spr_rdata,
    input  logic        spr_ack
);

    typedef enum logic [2:0] {
        IDLE,
        LOCAL,
        SPR_REQ,
        SPR_WAIT,
        ACK,
        RELEASE
    } state_t;

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [10:0] OFF_DCTRL   = 11'd0;
    localparam logic [10:0] OFF_DSTAT   = 11'd1;
`ifdef OSD_CDM_DU_HITCNT_EN
    localparam logic [10:0] OFF_DHITCNT = 11'd2;
`endif

    state_t           state;
    logic [15:0]      adr_q;
    logic             we_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic [CNT_W-1:0] cnt;

    logic             bp_en;
    logic             bp_stop;
    logic             timeout_err;
    logic             bp_stall;
    logic             du_stall_q;

    logic [10:0]      off;
    logic             local_wr;
    logic             wr_dctrl;
    logic             wr_dstat;
    logic             bp_set;
    logic             stall_fall;
    logic             timeout_hit;
    logic             bp_stall_next;
    logic [31:0]      local_rdata;

`ifdef OSD_CDM_DU_HITCNT_EN
    logic [31:0]      hitcnt;
    logic             wr_hitcnt;
`endif

    // ------------------------------------------------------------------------
    // Decode of the captured access (only meaningful in the LOCAL state)
    // ------------------------------------------------------------------------
    assign off         = adr_q[10:0];
    assign local_wr    = (state == LOCAL) && we_q;
    assign wr_dctrl    = local_wr && (off == OFF_DCTRL);
    assign wr_dstat    = local_wr && (off == OFF_DSTAT);
`ifdef OSD_CDM_DU_HITCNT_EN
    assign wr_hitcnt   = local_wr && (off == OFF_DHITCNT);
`endif

    assign bp_set      = bp_hit && bp_en;
    assign stall_fall  = du_stall_q && !du_stall_i;
    assign timeout_hit = (state == SPR_WAIT) && !spr_ack && (cnt == CNT_LAST);

    assign du_stall_o  = bp_stall;

    // Set has priority over both clearing sources.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // can leave it unassigned and infer a latch.
        bp_stall_next = bp_stall;
        if (bp_set) begin
            bp_stall_next = 1'b1;
        end else if (stall_fall || (wr_dstat && wdata_q[0])) begin
            bp_stall_next = 1'b0;
        end
    end

    always_comb begin
        local_rdata = '0;
        case (off)
            OFF_DCTRL:   local_rdata = {31'b0, bp_en};
            OFF_DSTAT:   local_rdata = {30'b0, timeout_err, bp_stop};
`ifdef OSD_CDM_DU_HITCNT_EN
            OFF_DHITCNT: local_rdata = hitcnt;
`endif
            default:     local_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Access FSM with registered du_* and spr_* outputs
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            adr_q     <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt       <= '0;
            du_ack_o  <= 1'b0;
            du_dat_o  <= '0;
            spr_req   <= 1'b0;
            spr_we    <= 1'b0;
            spr_addr  <= '0;
            spr_wdata <= '0;
        end else begin
            du_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (du_stb_i) begin
                        // Capture once; later changes on du_* are ignored.
                        adr_q   <= du_adr_i;
                        we_q    <= du_we_i;
                        wdata_q <= du_dat_i;
                        state   <= (du_adr_i[15:11] == DBG_GROUP) ? LOCAL : SPR_REQ;
                    end
                end
                LOCAL: begin
                    if (!we_q) rdata_q <= local_rdata;
                    state <= ACK;
                end
                SPR_REQ: begin
                    spr_req   <= 1'b1;
                    spr_we    <= we_q;
                    spr_addr  <= adr_q;
                    spr_wdata <= wdata_q;
                    cnt       <= '0;
                    state     <= SPR_WAIT;
                end
                SPR_WAIT: begin
                    if (spr_ack) begin
                        spr_req <= 1'b0;
                        spr_we  <= 1'b0;
                        if (!we_q) rdata_q <= spr_rdata;
                        state <= ACK;
                    end else if (timeout_hit) begin
                        // spr_req has now been high for TIMEOUT cycles.
                        spr_req <= 1'b0;
                        spr_we  <= 1'b0;
                        if (!we_q) rdata_q <= ERR_DATA;
                        state <= ACK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ACK: begin
                    du_ack_o <= 1'b1;
                    if (!we_q) du_dat_o <= rdata_q;
                    state <= RELEASE;
                end
                RELEASE: begin
                    // A strobe still held after the ack is not a new access.
                    if (!du_stb_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Debug control/status and stall tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bp_en       <= 1'b0;
            bp_stop     <= 1'b0;
            timeout_err <= 1'b0;
            bp_stall    <= 1'b0;
            du_stall_q  <= 1'b0;
            cpu_stall   <= 1'b0;
        end else begin
            du_stall_q <= du_stall_i;
            bp_stall   <= bp_stall_next;
            // Uses the next bp_stall so a breakpoint stalls the pipeline in
            // the same cycle du_stall_o rises.
            cpu_stall  <= du_stall_i || bp_stall_next;

            if (wr_dctrl) bp_en <= wdata_q[0];

            if (bp_set) begin
                bp_stop <= 1'b1;
            end else if (wr_dstat && wdata_q[0]) begin
                bp_stop <= 1'b0;
            end

            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (wr_dstat && wdata_q[1]) begin
                timeout_err <= 1'b0;
            end
        end
    end

`ifdef OSD_CDM_DU_HITCNT_EN
    // Saturating hit counter; a write in the same cycle as a hit clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hitcnt <= '0;
        end else if (wr_hitcnt) begin
            hitcnt <= '0;
        end else if (bp_set && (hitcnt != 32'hFFFF_FFFF)) begin
            hitcnt <= hitcnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/osd_cdm_du_responder.md
Name: osd_cdm_du_responder

Overview:
Core-side responder for the CDM debug-unit (du_*) interface. Accepts stall requests and register strobes issued by the CDM. Serves the local debug-group registers itself and forwards all other addresses to the CPU SPR port. Raises du_stall_o when the core halts on a breakpoint. Sits between the CDM and the CPU pipeline/SPR file, one instance per core.

Parameters:
DBG_GROUP, 5'd6, value of du_adr_i[15:11] that selects the local debug registers (0x3000-0x37FF)
TIMEOUT, 16, max cycles spr_req waits for spr_ack before error completion (>=2)
ERR_DATA, 32'hDEADBEEF, du_dat_o value returned on a timed-out read

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
du_stall_i  in  1  stall request from CDM, level
du_stall_o  out  1  core halted by breakpoint
du_stb_i  in  1  access strobe, held until du_ack_o
du_ack_o  out  1  one-cycle completion pulse
du_adr_i  in  16  register address
du_we_i  in  1  1=write, 0=read
du_dat_i  in  32  write data
du_dat_o  out  32  read data, valid in du_ack_o cycle and held until next access
cpu_stall  out  1  stall to pipeline
bp_hit  in  1  one-cycle breakpoint/trap pulse from core
spr_req  out  1  SPR access request, held until spr_ack or timeout
spr_we  out  1  SPR write enable
spr_addr  out  16  SPR address
spr_wdata  out  32  SPR write data
spr_rdata  in  32  SPR read data, valid with spr_ack
spr_ack  in  1  SPR completion pulse

Behaviour:
- Reset: all outputs 0; state IDLE; DCTRL=0, DSTAT=0, bp_stall=0.
- Local regs (du_adr_i[15:11]==DBG_GROUP): 0x3000 DCTRL (bit0 BP_EN, rest RAZ/WI); 0x3001 DSTAT (bit0 BP_STOP, bit1 TIMEOUT_ERR; write-1-to-clear); other group offsets RAZ/WI, still acked.
- FSM: IDLE -> (stb=1, addr local) LOCAL | (stb=1, else) SPR_REQ.
- LOCAL: perform read/write; -> ACK.
- SPR_REQ: drive spr_req=1, spr_we/addr/wdata from captured du_* inputs; -> SPR_WAIT.
- SPR_WAIT: on spr_ack capture spr_rdata -> ACK; counter reaching TIMEOUT -> drop spr_req, set DSTAT.TIMEOUT_ERR, du_dat_o=ERR_DATA on read -> ACK.
- ACK: du_ack_o=1 for exactly one cycle -> RELEASE.
- RELEASE: wait for du_stb_i=0 -> IDLE. Never re-acks a held strobe.
- Address/data/we captured at the IDLE exit edge; later changes ignored.
- Latency: local access acks 2 cycles after stb first sampled; SPR access acks 1 cycle after spr_ack sampled.
- Writes leave du_dat_o unchanged.
- bp_stall set on bp_hit when DCTRL.BP_EN=1 (also sets DSTAT.BP_STOP). Cleared on a du_stall_i 1->0 edge or by a W1C to DSTAT.BP_STOP. du_stall_o = bp_stall, registered.
- cpu_stall = du_stall_i | bp_stall, registered (1-cycle latency).
- bp_hit and a clearing event in the same cycle: set wins.
- bp_hit with BP_EN=0: ignored.
- SPR accesses permitted whether or not the core is stalled.
- Reset mid-access: spr_req drops the next cycle and no ack is issued; the CDM must re-issue the access.

Optional Feature:
OSD_CDM_DU_HITCNT_EN: adds DHITCNT at 0x3002, a 32-bit counter of qualified bp_hit events. Saturates at 0xFFFFFFFF. Any write clears it; reset 0. Without the macro, 0x3002 is RAZ/WI like other unused offsets.

Test Plan:
- Write 0x3000=1, then read 0x3000 -> read acks 2 cycles after stb with du_dat_o=0x00000001; no spr_req in either access.
- Read 0x8123, spr_ack 3 cycles after spr_req with spr_rdata=0xCAFEF00D -> spr_addr=0x8123, spr_we=0; du_ack_o one cycle after spr_ack, du_dat_o=0xCAFEF00D.
- Read 0x8000 with spr_ack never asserted -> spr_req drops after 16 cycles; du_dat_o=0xDEADBEEF; then read 0x3001 returns 0x2.
- BP_EN=1, pulse bp_hit -> du_stall_o=1 and cpu_stall=1 next cycle; du_stall_i 0->1->0 -> du_stall_o=0, cpu_stall=0.
- Hold du_stb_i high for 10 cycles after ack -> exactly one du_ack_o pulse, no second spr_req.
- Macro on, 3 qualified bp_hit pulses -> read 0x3002 returns 3; write 0x3002 -> reads 0. Macro off -> read 0x3002 returns 0.
